// File: rtl/counter_seq_ctrl.sv
// Sequencer that drives the enable/clear of an external up-counter and
// detects its terminal count, running one-shot or periodic (auto-reload) sequences.
module counter_seq_ctrl #(
    parameter int BW    = 3,
    parameter int RPT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             mode_i,
    input  logic [BW-1:0]    limit_i,
    input  logic [RPT_W-1:0] repeat_i,
    input  logic [BW-1:0]    counter_val_i,
    output logic             cnt_en_o,
    output logic             cnt_clr_o,
    output logic             busy_o,
    output logic             tick_o,
    output logic             done_o,
    output logic [RPT_W-1:0] period_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [BW-1:0]    limit_q;
    logic             mode_q;
    logic [RPT_W-1:0] repeat_q;
    logic [RPT_W-1:0] period_cnt;

    logic match;
    logic last_period;

    // A match ends the sequence in one-shot mode, or when the finite repeat count is reached.
    function automatic logic is_last_period(input logic             mode,
                                            input logic [RPT_W-1:0] rpt,
                                            input logic [RPT_W-1:0] pcnt);
        logic [RPT_W-1:0] next_pcnt;
        next_pcnt = pcnt + 1'b1;
        return !mode || ((rpt != '0) && (next_pcnt == rpt));
    endfunction

    assign match       = (counter_val_i == limit_q);
    assign last_period = is_last_period(mode_q, repeat_q, period_cnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            limit_q    <= '0;
            mode_q     <= 1'b0;
            repeat_q   <= '0;
            period_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && !stop_i) begin
                        limit_q    <= limit_i;
                        mode_q     <= mode_i;
                        repeat_q   <= repeat_i;
                        period_cnt <= '0;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= stop_i ? IDLE : RUN;
                end
                RUN: begin
                    if (stop_i) begin
                        state <= IDLE;
                    end else if (match) begin
                        period_cnt <= period_cnt + 1'b1;
                        if (last_period) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state; stop masks every RUN action in the same cycle.
    always_comb begin
        cnt_en_o  = 1'b0;
        cnt_clr_o = 1'b0;
        busy_o    = 1'b0;
        tick_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            CLEAR: begin
                busy_o    = 1'b1;
                cnt_clr_o = 1'b1;
            end
            RUN: begin
                busy_o = 1'b1;
                if (!stop_i) begin
                    cnt_en_o  = !match;
                    tick_o    = match;
                    cnt_clr_o = match && !last_period;
                end
            end
            DONE: begin
                done_o = 1'b1;
            end
            default: ;
        endcase
    end

    assign period_cnt_o = period_cnt;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a behavioural up-counter closes the loop, a vector
// table covers one-shot/periodic runs, hand sequences cover L=0, abort and async reset.
module tb_counter_seq_ctrl;

    localparam int BW    = 3;
    localparam int RPT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, stop, mode;
    logic [BW-1:0]    limit;
    logic [RPT_W-1:0] rpt;
    logic [BW-1:0]    cval;
    logic             cnt_en, cnt_clr, busy, tick, done;
    logic [RPT_W-1:0] pcnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Counter datapath model: clear has priority over enable, wraps at 2^BW.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cval <= '0;
        else if (cnt_clr) cval <= '0;
        else if (cnt_en)  cval <= cval + 1'b1;
    end

    counter_seq_ctrl #(.BW(BW), .RPT_W(RPT_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .stop_i       (stop),
        .mode_i       (mode),
        .limit_i      (limit),
        .repeat_i     (rpt),
        .counter_val_i(cval),
        .cnt_en_o     (cnt_en),
        .cnt_clr_o    (cnt_clr),
        .busy_o       (busy),
        .tick_o       (tick),
        .done_o       (done),
        .period_cnt_o (pcnt)
    );

    typedef struct {
        logic             start, stop, mode;
        logic [BW-1:0]    limit;
        logic [RPT_W-1:0] rpt;
        logic             en, clr, bsy, tck, dn;
        logic [RPT_W-1:0] pc;
        logic [BW-1:0]    cv;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, sp, md, input int lim, rp,
                       input logic en, clr, bsy, tck, dn, input int pc, cv);
        vec_t v;
        v.start = st; v.stop = sp; v.mode = md;
        v.limit = lim[BW-1:0]; v.rpt = rp[RPT_W-1:0];
        v.en = en; v.clr = clr; v.bsy = bsy; v.tck = tck; v.dn = dn;
        v.pc = pc[RPT_W-1:0]; v.cv = cv[BW-1:0];
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic en, clr, bsy, tck, dn, input int pc);
        chk({tag, " en"},   cnt_en,  en);
        chk({tag, " clr"},  cnt_clr, clr);
        chk({tag, " busy"}, busy,    bsy);
        chk({tag, " tick"}, tick,    tck);
        chk({tag, " done"}, done,    dn);
        chk({tag, " pcnt"}, pcnt,    pc);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; mode = 0; limit = '0; rpt = '0;

        // One-shot L=5; start sampled at edge k; tick after edge k+6, done after k+7.
        //   st sp md lim rp   en clr bsy tck dn pc cv
        add(1, 0, 0, 5, 0,   0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 5, 0,   0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 5, 0,   1, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 5, 0,   1, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 5, 0,   1, 0, 1, 0, 0, 0, 2);
        add(0, 0, 0, 5, 0,   1, 0, 1, 0, 0, 0, 3);
        add(0, 0, 0, 5, 0,   1, 0, 1, 0, 0, 0, 4);
        add(0, 0, 0, 5, 0,   0, 0, 1, 1, 0, 0, 5);
        add(0, 0, 0, 5, 0,   0, 0, 0, 0, 1, 1, 5);
        add(0, 0, 0, 5, 0,   0, 0, 0, 0, 0, 1, 5);
        // Periodic L=2 repeat=3; starts mid-RUN and in DONE with other config are ignored.
        add(1, 0, 1, 2, 3,   0, 0, 0, 0, 0, 1, 5);
        add(0, 0, 1, 2, 3,   0, 1, 1, 0, 0, 0, 5);
        add(0, 0, 1, 2, 3,   1, 0, 1, 0, 0, 0, 0);
        add(1, 0, 0, 7, 1,   1, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 7, 1,   0, 1, 1, 1, 0, 0, 2);
        add(0, 0, 0, 7, 1,   1, 0, 1, 0, 0, 1, 0);
        add(1, 0, 0, 4, 1,   1, 0, 1, 0, 0, 1, 1);
        add(0, 0, 0, 7, 1,   0, 1, 1, 1, 0, 1, 2);
        add(0, 0, 0, 7, 1,   1, 0, 1, 0, 0, 2, 0);
        add(0, 0, 0, 7, 1,   1, 0, 1, 0, 0, 2, 1);
        add(0, 0, 0, 7, 1,   0, 0, 1, 1, 0, 2, 2);
        add(1, 0, 0, 1, 1,   0, 0, 0, 0, 1, 3, 2);
        add(0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 3, 2);

        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            @(negedge clk);
            start = vecs[i].start; stop = vecs[i].stop; mode = vecs[i].mode;
            limit = vecs[i].limit; rpt = vecs[i].rpt;
            #1;
            tag = $sformatf("row%0d", i);
            chk_all(tag, vecs[i].en, vecs[i].clr, vecs[i].bsy, vecs[i].tck, vecs[i].dn, vecs[i].pc);
            chk({tag, " cval"}, cval, vecs[i].cv);
        end

        // Periodic L=0, infinite: tick every RUN cycle, period count wraps at 16.
        @(negedge clk);
        start = 1; mode = 1; limit = 0; rpt = 0;
        @(negedge clk);
        start = 0;
        chk("l0 clear", cnt_clr, 1);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk($sformatf("l0 tick%0d", n), tick, 1);
            chk($sformatf("l0 en%0d", n), cnt_en, 0);
        end
        @(negedge clk);
        chk("l0 wrap pcnt", pcnt, 4);
        stop = 1;
        #1;
        chk_all("l0 stop", 0, 0, 1, 0, 0, 4);
        @(negedge clk);
        stop = 0;
        chk_all("l0 after stop", 0, 0, 0, 0, 0, 4);
        @(negedge clk);
        chk("l0 no done", done, 0);

        // Abort a one-shot L=7 when the counter shows 3.
        @(negedge clk);
        start = 1; mode = 0; limit = 7; rpt = 0;
        @(negedge clk);
        start = 0;
        begin
            bit found = 0;
            for (int n = 0; n < 20 && !found; n++) begin
                @(negedge clk);
                if (tick) chk("abort early tick", tick, 0);
                if (cval == 3) found = 1;
            end
            chk("abort reached cval3", found, 1);
        end
        stop = 1;
        #1;
        chk_all("abort cycle", 0, 0, 1, 0, 0, 0);
        @(negedge clk);
        stop = 0;
        chk_all("abort next", 0, 0, 0, 0, 0, 0);
        chk("abort cval held", cval, 3);
        @(negedge clk);
        chk("abort no done", done, 0);

        // Async reset while running, then a fresh one-shot L=1.
        @(negedge clk);
        start = 1; mode = 0; limit = 5;
        @(negedge clk);
        start = 0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_all("post reset idle", 0, 0, 0, 0, 0, 0);
        start = 1; limit = 1; mode = 0;
        @(negedge clk);
        start = 0;
        chk_all("rs clear", 0, 1, 1, 0, 0, 0);
        @(negedge clk);
        chk_all("rs run0", 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        chk_all("rs tick", 0, 0, 1, 1, 0, 0);
        @(negedge clk);
        chk_all("rs done", 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk_all("rs idle", 0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
